// File: rtl/scr1_mem_arb_pkg.sv
// Shared types for the two-to-one memory arbiter.
// Contents: memory command/width/response encodings, widths of the core memory
// interfaces, the FIFO owner-ID encoding and the lock FSM state encoding.
package scr1_mem_arb_pkg;

    localparam int unsigned SCR1_IMEM_AWIDTH = 32;
    localparam int unsigned SCR1_IMEM_DWIDTH = 32;
    localparam int unsigned SCR1_DMEM_AWIDTH = 32;
    localparam int unsigned SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_IDLE = 2'b00,
        SCR1_MEM_RESP_RDY  = 2'b01,
        SCR1_MEM_RESP_ER   = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic {
        OWN_IMEM = 1'b0,
        OWN_DMEM = 1'b1
    } type_scr1_mem_arb_owner_e;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } type_scr1_mem_arb_fsm_e;

endpackage

// File: rtl/scr1_mem_arb_if.sv
// Memory request/response port bundle, used for imem, dmem and the shared port.
// master: drives req/cmd/width/addr/wdata, receives req_ack/rdata/resp.
// slave : the opposite direction.
interface scr1_mem_arb_if;
    import scr1_mem_arb_pkg::*;

    logic                 req;
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e width;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic                 req_ack;
    logic [31:0]          rdata;
    type_scr1_mem_resp_e  resp;

    modport master (
        output req, cmd, width, addr, wdata,
        input  req_ack, rdata, resp
    );

    modport slave (
        input  req, cmd, width, addr, wdata,
        output req_ack, rdata, resp
    );

endinterface

// File: rtl/scr1_mem_arb_ordfifo.sv
// In-order owner-ID FIFO: records which requester issued each outstanding
// transaction so responses can be routed back in order.
// Ports: clk, rst_n (sync, active-low), push/push_owner, pop,
//        head (owner of oldest entry), empty, full, count.
module scr1_mem_arb_ordfifo
    import scr1_mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  type_scr1_mem_arb_owner_e push_owner,
    input  logic                     pop,
    output type_scr1_mem_arb_owner_e head,
    output logic                     empty,
    output logic                     full,
    output logic [2:0]               count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    type_scr1_mem_arb_owner_e store [DEPTH];
    logic [PtrW-1:0]          wr_ptr;
    logic [PtrW-1:0]          rd_ptr;
    logic [2:0]               cnt;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_owner;
    end

    assign head  = store[rd_ptr];
    assign empty = (cnt == 3'd0);
    assign full  = (cnt == 3'(DEPTH));
    assign count = cnt;

endmodule

// File: rtl/scr1_mem_arb.sv
// Two-to-one memory arbiter: merges imem and dmem onto one shared memory port.
// Data-first priority with an anti-starvation counter, lock-until-ack on a
// presented request, and in-order response routing through an owner FIFO.
// Ports: clk, rst_n (sync, active-low); imem, dmem (slave side of requesters);
//        mem (master side toward memory); orphan_resp (response with no owner).
module scr1_mem_arb
    import scr1_mem_arb_pkg::*;
#(
    parameter int unsigned OUTST_DEPTH   = 2,
    parameter int unsigned DMEM_MAX_WINS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    scr1_mem_arb_if.slave  imem,
    scr1_mem_arb_if.slave  dmem,
    scr1_mem_arb_if.master mem,
    output logic           orphan_resp
);

    type_scr1_mem_arb_fsm_e   fsm_state;
    logic [3:0]               win_cnt;
    type_scr1_mem_arb_owner_e sel_owner;
    logic                     sel_req;
    logic                     present;
    logic                     accept;
    logic                     resp_valid;
    logic                     fifo_pop;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [2:0]               fifo_count;
    type_scr1_mem_arb_owner_e fifo_head;

    // Selection: frozen while locked; otherwise dmem first unless imem has
    // waited through DMEM_MAX_WINS consecutive dmem grants.
    always_comb begin
        sel_owner = OWN_IMEM;
        unique case (fsm_state)
            LOCK_I: sel_owner = OWN_IMEM;
            LOCK_D: sel_owner = OWN_DMEM;
            default: begin
                if (dmem.req && !(imem.req && win_cnt == 4'(DMEM_MAX_WINS))) begin
                    sel_owner = OWN_DMEM;
                end
            end
        endcase
    end

    assign sel_req = (sel_owner == OWN_DMEM) ? dmem.req : imem.req;
    // Full FIFO blocks presentation; mem.req never depends on mem.req_ack.
    assign present = rst_n && sel_req && !fifo_full;
    assign accept  = present && mem.req_ack;

    assign mem.req      = present;
    assign imem.req_ack = accept && (sel_owner == OWN_IMEM);
    assign dmem.req_ack = accept && (sel_owner == OWN_DMEM);

    always_comb begin
        mem.cmd   = SCR1_MEM_CMD_RD;
        mem.width = SCR1_MEM_WIDTH_WORD;
        mem.addr  = '0;
        mem.wdata = '0;
        if (rst_n) begin
            if (sel_owner == OWN_DMEM) begin
                mem.cmd   = dmem.cmd;
                mem.width = dmem.width;
                mem.addr  = 32'(dmem.addr);
                mem.wdata = dmem.wdata;
            end else begin
                mem.cmd  = imem.cmd;
                mem.addr = 32'(imem.addr);
            end
        end
    end

    // Response routing: the FIFO head owns the current response.
    assign resp_valid  = rst_n && (mem.resp != SCR1_MEM_RESP_IDLE);
    assign fifo_pop    = resp_valid && !fifo_empty;
    assign orphan_resp = resp_valid && fifo_empty;

    always_comb begin
        imem.resp  = SCR1_MEM_RESP_IDLE;
        imem.rdata = '0;
        dmem.resp  = SCR1_MEM_RESP_IDLE;
        dmem.rdata = '0;
        if (fifo_pop) begin
            if (fifo_head == OWN_DMEM) begin
                dmem.resp  = mem.resp;
                dmem.rdata = mem.rdata;
            end else begin
                imem.resp  = mem.resp;
                imem.rdata = mem.rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_state <= FREE;
            win_cnt   <= '0;
        end else begin
            if (accept) begin
                fsm_state <= FREE;
            end else if (present) begin
                fsm_state <= (sel_owner == OWN_DMEM) ? LOCK_D : LOCK_I;
            end else if (!sel_req) begin
                // Requester withdrew its request; release the lock.
                fsm_state <= FREE;
            end

            if (!imem.req || (accept && sel_owner == OWN_IMEM)) begin
                win_cnt <= '0;
            end else if (accept && sel_owner == OWN_DMEM &&
                         win_cnt < 4'(DMEM_MAX_WINS)) begin
                win_cnt <= win_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (fifo_count <= 3'(OUTST_DEPTH));
        end
    end

    scr1_mem_arb_ordfifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_ordfifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (accept),
        .push_owner (sel_owner),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_scr1_mem_arb.sv
// Directed, table-driven bench for scr1_mem_arb (OUTST_DEPTH=2, DMEM_MAX_WINS=4).
module tb_scr1_mem_arb;
    import scr1_mem_arb_pkg::*;

    localparam logic [31:0] IA = 32'h0000_0100;
    localparam logic [31:0] DA = 32'h0000_0200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic orphan_resp;

    always #5 clk = ~clk;

    scr1_mem_arb_if imem_if ();
    scr1_mem_arb_if dmem_if ();
    scr1_mem_arb_if mem_if ();

    scr1_mem_arb #(
        .OUTST_DEPTH   (2),
        .DMEM_MAX_WINS (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem_if.slave),
        .dmem        (dmem_if.slave),
        .mem         (mem_if.master),
        .orphan_resp (orphan_resp)
    );

    typedef struct {
        logic                i_req;
        logic                d_req;
        logic                ack;
        type_scr1_mem_resp_e resp;
        logic [31:0]         rdata;
        logic                e_req;
        logic                e_iack;
        logic                e_dack;
        logic [31:0]         e_addr;
        type_scr1_mem_resp_e e_iresp;
        type_scr1_mem_resp_e e_dresp;
        logic [31:0]         e_irdata;
        logic [31:0]         e_drdata;
        logic                e_orph;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    localparam type_scr1_mem_resp_e RI = SCR1_MEM_RESP_IDLE;
    localparam type_scr1_mem_resp_e RR = SCR1_MEM_RESP_RDY;
    localparam type_scr1_mem_resp_e RE = SCR1_MEM_RESP_ER;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic i, input logic d, input logic ack,
                         input type_scr1_mem_resp_e resp, input logic [31:0] rdata);
        imem_if.req    = i;
        dmem_if.req    = d;
        mem_if.req_ack = ack;
        mem_if.resp    = resp;
        mem_if.rdata   = rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fixed payloads; imem width/wdata are deliberately non-default to show forcing.
        imem_if.cmd   = SCR1_MEM_CMD_RD;
        imem_if.width = SCR1_MEM_WIDTH_BYTE;
        imem_if.addr  = IA;
        imem_if.wdata = 32'hFFFF_FFFF;
        dmem_if.cmd   = SCR1_MEM_CMD_WR;
        dmem_if.width = SCR1_MEM_WIDTH_HWORD;
        dmem_if.addr  = DA;
        dmem_if.wdata = 32'hCAFE_F00D;
        drive(1'b0, 1'b0, 1'b0, RI, 32'h0);

        // i d ack resp rdata | req iack dack addr iresp dresp irdata drdata orph
        vq.push_back('{0,0,0,RI,32'h0,        0,0,0,IA,RI,RI,32'h0,0,0}); // reset state
        // imem burst: two accepts, stall at full, third after first RDY
        vq.push_back('{1,0,1,RI,32'h0,        1,1,0,IA,RI,RI,32'h0,0,0});
        vq.push_back('{1,0,1,RI,32'h0,        1,1,0,IA,RI,RI,32'h0,0,0});
        vq.push_back('{1,0,1,RI,32'h0,        0,0,0,IA,RI,RI,32'h0,0,0});
        vq.push_back('{1,0,1,RR,32'hAAAA0001, 0,0,0,IA,RR,RI,32'hAAAA0001,0,0});
        vq.push_back('{1,0,1,RI,32'h0,        1,1,0,IA,RI,RI,32'h0,0,0});
        vq.push_back('{0,0,0,RR,32'hAAAA0002, 0,0,0,IA,RR,RI,32'hAAAA0002,0,0});
        vq.push_back('{0,0,0,RR,32'hAAAA0003, 0,0,0,IA,RR,RI,32'hAAAA0003,0,0});
        // both requesting: D,D,D,D,I,D,D,D,D,I; push+pop keeps count at 1
        vq.push_back('{1,1,1,RI,32'h0,        1,0,1,DA,RI,RI,32'h0,0,0});
        vq.push_back('{1,1,1,RR,32'hD0000001, 1,0,1,DA,RI,RR,32'h0,32'hD0000001,0});
        vq.push_back('{1,1,1,RR,32'hD0000002, 1,0,1,DA,RI,RR,32'h0,32'hD0000002,0});
        vq.push_back('{1,1,1,RR,32'hD0000003, 1,0,1,DA,RI,RR,32'h0,32'hD0000003,0});
        vq.push_back('{1,1,1,RR,32'hD0000004, 1,1,0,IA,RI,RR,32'h0,32'hD0000004,0});
        vq.push_back('{1,1,1,RR,32'h1A000005, 1,0,1,DA,RR,RI,32'h1A000005,0,0});
        vq.push_back('{1,1,1,RR,32'hD0000006, 1,0,1,DA,RI,RR,32'h0,32'hD0000006,0});
        vq.push_back('{1,1,1,RR,32'hD0000007, 1,0,1,DA,RI,RR,32'h0,32'hD0000007,0});
        vq.push_back('{1,1,1,RR,32'hD0000008, 1,0,1,DA,RI,RR,32'h0,32'hD0000008,0});
        vq.push_back('{1,1,1,RR,32'hD0000009, 1,1,0,IA,RI,RR,32'h0,32'hD0000009,0});
        vq.push_back('{0,0,0,RE,32'h1E00000A, 0,0,0,IA,RE,RI,32'h1E00000A,0,0});
        // dmem locked for 3 unacked cycles while imem waits
        vq.push_back('{0,1,0,RI,32'h0,        1,0,0,DA,RI,RI,32'h0,0,0});
        vq.push_back('{1,1,0,RI,32'h0,        1,0,0,DA,RI,RI,32'h0,0,0});
        vq.push_back('{1,1,0,RI,32'h0,        1,0,0,DA,RI,RI,32'h0,0,0});
        vq.push_back('{1,1,1,RI,32'h0,        1,0,1,DA,RI,RI,32'h0,0,0});
        vq.push_back('{1,0,1,RI,32'h0,        1,1,0,IA,RI,RI,32'h0,0,0});
        vq.push_back('{0,0,0,RR,32'h00000011, 0,0,0,IA,RI,RR,32'h0,32'h11,0});
        vq.push_back('{0,0,0,RE,32'h00000012, 0,0,0,IA,RE,RI,32'h12,0,0});
        // interleaved I,D then RDY, ER
        vq.push_back('{1,0,1,RI,32'h0,        1,1,0,IA,RI,RI,32'h0,0,0});
        vq.push_back('{0,1,1,RI,32'h0,        1,0,1,DA,RI,RI,32'h0,0,0});
        vq.push_back('{0,0,0,RR,32'h00000022, 0,0,0,IA,RR,RI,32'h22,0,0});
        vq.push_back('{0,0,0,RE,32'h00000033, 0,0,0,IA,RI,RE,32'h0,32'h33,0});
        // response with empty FIFO is an orphan
        vq.push_back('{0,0,0,RR,32'h00000044, 0,0,0,IA,RI,RI,32'h0,0,1});
        vq.push_back('{0,0,0,RI,32'h0,        0,0,0,IA,RI,RI,32'h0,0,0});

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vq[k]) begin
            drive(vq[k].i_req, vq[k].d_req, vq[k].ack, vq[k].resp, vq[k].rdata);
            @(negedge clk);
            check($sformatf("v%0d mem_req", k),      32'(mem_if.req),       32'(vq[k].e_req));
            check($sformatf("v%0d imem_req_ack", k), 32'(imem_if.req_ack),  32'(vq[k].e_iack));
            check($sformatf("v%0d dmem_req_ack", k), 32'(dmem_if.req_ack),  32'(vq[k].e_dack));
            check($sformatf("v%0d mem_addr", k),     mem_if.addr,           vq[k].e_addr);
            check($sformatf("v%0d imem_resp", k),    32'(imem_if.resp),     32'(vq[k].e_iresp));
            check($sformatf("v%0d dmem_resp", k),    32'(dmem_if.resp),     32'(vq[k].e_dresp));
            check($sformatf("v%0d imem_rdata", k),   imem_if.rdata,         vq[k].e_irdata);
            check($sformatf("v%0d dmem_rdata", k),   dmem_if.rdata,         vq[k].e_drdata);
            check($sformatf("v%0d orphan_resp", k),  32'(orphan_resp),      32'(vq[k].e_orph));
            next_cycle();
        end

        // Reset with two outstanding, then a late response becomes an orphan.
        drive(1'b1, 1'b0, 1'b1, RI, 32'h0);
        @(negedge clk);
        check("r1 imem_req_ack", 32'(imem_if.req_ack), 32'd1);
        next_cycle();
        drive(1'b0, 1'b1, 1'b1, RI, 32'h0);
        @(negedge clk);
        check("r2 dmem_req_ack", 32'(dmem_if.req_ack), 32'd1);
        next_cycle();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, RR, 32'h5555_5555);
        @(negedge clk);
        check("rst mem_req",      32'(mem_if.req),      32'd0);
        check("rst imem_req_ack", 32'(imem_if.req_ack), 32'd0);
        check("rst dmem_req_ack", 32'(dmem_if.req_ack), 32'd0);
        check("rst imem_resp",    32'(imem_if.resp),    32'(RI));
        check("rst dmem_resp",    32'(dmem_if.resp),    32'(RI));
        check("rst imem_rdata",   imem_if.rdata,        32'h0);
        check("rst orphan_resp",  32'(orphan_resp),     32'd0);
        check("rst mem_cmd",      32'(mem_if.cmd),      32'(SCR1_MEM_CMD_RD));
        check("rst mem_width",    32'(mem_if.width),    32'(SCR1_MEM_WIDTH_WORD));
        check("rst mem_addr",     mem_if.addr,          32'h0);
        check("rst mem_wdata",    mem_if.wdata,         32'h0);
        next_cycle();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, RR, 32'h6666_6666);
        @(negedge clk);
        check("late orphan_resp", 32'(orphan_resp),  32'd1);
        check("late imem_resp",   32'(imem_if.resp), 32'(RI));
        check("late dmem_resp",   32'(dmem_if.resp), 32'(RI));
        check("late dmem_rdata",  dmem_if.rdata,     32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, RI, 32'h0);
        @(negedge clk);
        check("late orphan_resp end", 32'(orphan_resp), 32'd0);
        next_cycle();

        // imem fields are forced to WORD / zero write data.
        drive(1'b1, 1'b0, 1'b0, RI, 32'h0);
        @(negedge clk);
        check("imem mem_req",   32'(mem_if.req),   32'd1);
        check("imem mem_width", 32'(mem_if.width), 32'(SCR1_MEM_WIDTH_WORD));
        check("imem mem_wdata", mem_if.wdata,      32'h0);
        next_cycle();
        // Locked on imem: dmem does not steal the slot despite its priority.
        drive(1'b1, 1'b1, 1'b1, RI, 32'h0);
        @(negedge clk);
        check("lock_i imem_req_ack", 32'(imem_if.req_ack), 32'd1);
        check("lock_i dmem_req_ack", 32'(dmem_if.req_ack), 32'd0);
        check("lock_i mem_addr",     mem_if.addr,          IA);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, RI, 32'h0);
        @(negedge clk);
        check("dmem mem_cmd",   32'(mem_if.cmd),   32'(SCR1_MEM_CMD_WR));
        check("dmem mem_width", 32'(mem_if.width), 32'(SCR1_MEM_WIDTH_HWORD));
        check("dmem mem_wdata", mem_if.wdata,      32'hCAFE_F00D);
        check("dmem mem_addr",  mem_if.addr,       DA);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scr1_mem_arb.md
# scr1_mem_arb

Two-to-one memory arbiter that merges the core's instruction and data memory interfaces onto one shared memory port. It sits between `scr1_core_top` (imem/dmem) and a single-ported memory or bridge. It arbitrates new requests with data-first priority and an anti-starvation counter. It tracks the owner of each outstanding transaction in an in-order FIFO and routes each response back to the requester that issued it.

## Interface
Parameters:
- `OUTST_DEPTH`, default 2: maximum outstanding accepted-but-unanswered transactions; range 1..4.
- `DMEM_MAX_WINS`, default 4: consecutive dmem grants allowed while imem waits before imem gets priority; range 1..15.

Ports:
- `clk`  in  1  core clock; the block has one clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `imem_req`  in  1  instruction request.
- `imem_cmd`  in  type_scr1_mem_cmd_e  instruction command; always RD in practice.
- `imem_addr`  in  `SCR1_IMEM_AWIDTH`  instruction address.
- `imem_req_ack`  out  1  instruction request accepted.
- `imem_rdata`  out  `SCR1_IMEM_DWIDTH`  instruction read data.
- `imem_resp`  out  type_scr1_mem_resp_e  instruction response.
- `dmem_req`  in  1  data request.
- `dmem_cmd`  in  type_scr1_mem_cmd_e  data command (RD/WR).
- `dmem_width`  in  type_scr1_mem_width_e  data access width.
- `dmem_addr`  in  `SCR1_DMEM_AWIDTH`  data address.
- `dmem_wdata`  in  `SCR1_DMEM_DWIDTH`  data write data.
- `dmem_req_ack`  out  1  data request accepted.
- `dmem_rdata`  out  `SCR1_DMEM_DWIDTH`  data read data.
- `dmem_resp`  out  type_scr1_mem_resp_e  data response.
- `mem_req`  out  1  shared-port request.
- `mem_cmd`  out  type_scr1_mem_cmd_e  shared-port command.
- `mem_width`  out  type_scr1_mem_width_e  shared-port width; forced WORD for imem.
- `mem_addr`  out  32  shared-port address; imem/dmem addresses are zero-extended to 32.
- `mem_wdata`  out  32  shared-port write data; 0 for imem.
- `mem_req_ack`  in  1  shared-port accept.
- `mem_rdata`  in  32  shared-port read data.
- `mem_resp`  in  type_scr1_mem_resp_e  shared-port response (IDLE/RDY/ER).
- `orphan_resp`  out  1  one-cycle pulse when a non-IDLE `mem_resp` arrives with the FIFO empty.

## Operation
- Handshake on each port: a transaction is accepted in a cycle where req=1 and req_ack=1. Responses return in order, one per cycle at most; any resp value other than IDLE retires the transaction.
- FSM states:
  - FREE: no pending grant. Selection is made combinationally.
  - LOCK_I: imem presented but not yet acked.
  - LOCK_D: dmem presented but not yet acked.
- Selection in FREE:
  - Only one requester active: that one.
  - Both active: dmem wins, unless `win_cnt` == `DMEM_MAX_WINS`, in which case imem wins.
- Request gating: no request reaches `mem_req` while FIFO count == `OUTST_DEPTH`. There is no same-cycle pop bypass.
- Presentation without ack moves the FSM to LOCK_x. In LOCK_x the selection is frozen to x until `mem_req_ack`, even if the other requester is active; then the FSM returns to FREE.
- Ack with presentation: on the acked cycle, push the owner (I/D) into the FIFO.
- `win_cnt` (4 bits):
  - Increments on a dmem accept while `imem_req`=1.
  - Clears on any imem accept or when `imem_req`=0.
  - Saturates at `DMEM_MAX_WINS`.
- Response routing: the FIFO head selects the destination. `mem_resp`/`mem_rdata` are driven to the head owner. The other port sees resp=IDLE and rdata=0. Pop on non-IDLE `mem_resp`.
- Simultaneous push and pop: count is unchanged and the head advances.
- Empty FIFO with a non-IDLE response: the response is dropped, both ports see IDLE, and `orphan_resp` pulses.
- Reset (also mid-transaction):
  - FSM goes to FREE, FIFO is emptied, `win_cnt`=0.
  - Responses that arrive late are orphans.
- Outputs during reset:
  - `mem_req`=0; `imem_req_ack`=`dmem_req_ack`=0.
  - resp outputs IDLE; rdata 0; `orphan_resp`=0.
  - `mem_cmd`/`mem_width`/`mem_addr`/`mem_wdata` are driven from imem defaults (RD/WORD/0/0).

## Timing
- Request path is combinational: `x_req` → `mem_req` in the same cycle. `mem_req_ack` → `x_req_ack` in the same cycle.
- Response path is combinational: `mem_resp` → owner resp in the same cycle. There is no added latency.
- The FIFO push/pop, FSM and `win_cnt` update on the rising edge of `clk`.
- A request gated by a full FIFO is presented one cycle after the pop that frees an entry.
- Every output is a function of the current inputs and registered state only. There is no combinational loop through `mem_req_ack`.

## Structure
- Add to `scr1_memif.svh`:
  - `type_scr1_mem_arb_owner_e` (OWN_IMEM=0, OWN_DMEM=1).
  - `type_scr1_mem_arb_fsm_e` (FREE/LOCK_I/LOCK_D).
- One sub-module: `scr1_mem_arb_ordfifo`. It is an owner-ID FIFO, 1 bit wide and `OUTST_DEPTH` deep, with push, pop, head, empty, full and count.
- Arbitration, lock FSM and routing live in the top.

## Test plan
- imem-only burst of 3 reads, `mem_req_ack`=1 every cycle, responses RDY in later cycles → 2 accepts, then a stall at full until the first RDY; imem_rdata matches the data, dmem_resp stays IDLE.
- Both requesting continuously, `DMEM_MAX_WINS`=4 → grant sequence D,D,D,D,I,D,D,D,D,I.
- dmem presented, `mem_req_ack`=0 for 3 cycles, imem asserted meanwhile → `mem_addr` stays on dmem_addr until the ack; only then is imem granted.
- Interleaved accepts I,D with responses RDY then ER → imem_resp=RDY first; dmem_resp=ER next cycle.
- Push and pop in the same cycle at count=1 → count stays 1 and the new owner becomes the head.
- Assert `rst_n`=0 with 2 outstanding, release, then inject `mem_resp`=RDY → both ports IDLE and `orphan_resp` pulses for exactly 1 cycle.
